// File: rtl/mod_n_digit_counter_pkg.sv
// Shared definitions for the modulo-N digit counter: width helper,
// clock-digit moduli and the count-direction encoding.
package counter_pkg;

  // Smallest r such that 2**r >= n; usable in constant expressions.
  function automatic int clog2_f(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int SEC_LO_MOD = 10;
  localparam int SEC_HI_MOD = 6;
  localparam int HR_MOD     = 24;

  typedef enum logic {
    CNT_DN = 1'b0,
    CNT_UP = 1'b1
  } cnt_dir_t;

endpackage

// File: rtl/mod_n_digit_counter_if.sv
// Control/status bundle of one counter digit.
// Optional load path is present only when MOD_N_COUNTER_LOAD_EN is defined.
interface mod_n_digit_counter_if #(
  parameter int WIDTH = 3
) ();

  logic             cnt_en;
  logic             up_dn;
  logic             set_time;
  logic             set_inc;
`ifdef MOD_N_COUNTER_LOAD_EN
  logic             load;
  logic [WIDTH-1:0] load_val;
`endif
  logic [WIDTH-1:0] count;
  logic             carry;
  logic             at_term;

`ifdef MOD_N_COUNTER_LOAD_EN
  modport master (output cnt_en, up_dn, set_time, set_inc, load, load_val,
                  input  count, carry, at_term);
  modport slave  (input  cnt_en, up_dn, set_time, set_inc, load, load_val,
                  output count, carry, at_term);
`else
  modport master (output cnt_en, up_dn, set_time, set_inc,
                  input  count, carry, at_term);
  modport slave  (input  cnt_en, up_dn, set_time, set_inc,
                  output count, carry, at_term);
`endif

endinterface

// File: rtl/mod_n_digit_counter_edge.sv
// Rising-edge detector for the set-mode step request.
// The delayed copy is sampled every cycle regardless of counter mode.
module rise_edge_det (
  input  logic clkmain,
  input  logic clear_n,
  input  logic d,
  output logic q_pulse
);

  logic d_q;

  // Register the previous level of d.
  always_ff @(posedge clkmain or negedge clear_n) begin
    // NOTE: non-blocking assignment in clocked logic so every register samples pre-edge values.
    if (!clear_n) d_q <= 1'b0;
    else          d_q <= d;
  end

  assign q_pulse = d & ~d_q;

endmodule

// File: rtl/mod_n_digit_counter.sv
// Modulo-N up/down digit counter with carry/borrow chaining and
// edge-stepped set mode. Define MOD_N_COUNTER_LOAD_EN to add a
// synchronous parallel load path.
module mod_n_digit_counter
  import counter_pkg::*;
#(
  parameter int MODULUS = 6,
  parameter int WIDTH   = 3
) (
  input  logic                  clkmain,
  input  logic                  clear_n,
  mod_n_digit_counter_if.slave  bus
);

  // Reject moduli that cannot be represented in the count width.
  generate
    if (MODULUS < 2 || WIDTH < clog2_f(MODULUS)) begin : g_bad_param
      $error("mod_n_digit_counter: MODULUS must be >= 2 and fit in WIDTH bits");
    end
  endgenerate

  localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic             carry_q;
  logic             set_edge;
  logic [WIDTH:0]   step_nxt;
  cnt_dir_t         dir;

  // One step in the given direction; returns {wrap, next_count}.
  // Out-of-range counts are treated as a wrap so the digit self-corrects.
  function automatic logic [WIDTH:0] step_f(input logic [WIDTH-1:0] c,
                                            input cnt_dir_t d);
    if (d == CNT_UP) begin
      // Guarded by the terminal compare, so c + 1 can never pass 2**WIDTH.
      if (c >= TERM) return {1'b1, {WIDTH{1'b0}}};
      else           return {1'b0, c + WIDTH'(1)};
    end else begin
      if (c == '0 || c > TERM) return {1'b1, TERM};
      else                     return {1'b0, c - WIDTH'(1)};
    end
  endfunction

  rise_edge_det u_set_edge (
    .clkmain (clkmain),
    .clear_n (clear_n),
    .d       (bus.set_inc),
    .q_pulse (set_edge)
  );

  assign dir      = cnt_dir_t'(bus.up_dn);
  assign step_nxt = step_f(count_q, dir);

  // Counter core: load > set mode > count enable > hold.
  always_ff @(posedge clkmain or negedge clear_n) begin
    if (!clear_n) begin
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
`ifdef MOD_N_COUNTER_LOAD_EN
      if (bus.load) begin
        count_q <= (bus.load_val > TERM) ? TERM : bus.load_val;
        carry_q <= 1'b0;
      end else
`endif
      if (bus.set_time) begin
        // One digit is set at a time, so nothing propagates downstream.
        carry_q <= 1'b0;
        if (set_edge) count_q <= step_nxt[WIDTH-1:0];
      end else if (bus.cnt_en) begin
        {carry_q, count_q} <= step_nxt;
      end else begin
        carry_q <= 1'b0;
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.carry   = carry_q;
  assign bus.at_term = (dir == CNT_UP) ? (count_q == TERM) : (count_q == '0);

endmodule

// File: tb/tb_mod_n_digit_counter.sv
// Self-checking bench: four digits (mod 6, 10, 16, 24) driven in
// parallel and compared against a modular-arithmetic reference model.
module tb_mod_n_digit_counter;
  import counter_pkg::*;

  localparam int N = 4;

  logic       clkmain = 1'b0;
  logic       clear_n;
  logic       cnt_en, up_dn, set_time, set_inc;
  logic       load;
  logic [4:0] load_val;

  always #5 clkmain = ~clkmain;

  mod_n_digit_counter_if #(.WIDTH(3)) if0 ();
  mod_n_digit_counter_if #(.WIDTH(4)) if1 ();
  mod_n_digit_counter_if #(.WIDTH(4)) if2 ();
  mod_n_digit_counter_if #(.WIDTH(5)) if3 ();

  assign if0.cnt_en = cnt_en;  assign if0.up_dn = up_dn;
  assign if0.set_time = set_time;  assign if0.set_inc = set_inc;
  assign if1.cnt_en = cnt_en;  assign if1.up_dn = up_dn;
  assign if1.set_time = set_time;  assign if1.set_inc = set_inc;
  assign if2.cnt_en = cnt_en;  assign if2.up_dn = up_dn;
  assign if2.set_time = set_time;  assign if2.set_inc = set_inc;
  assign if3.cnt_en = cnt_en;  assign if3.up_dn = up_dn;
  assign if3.set_time = set_time;  assign if3.set_inc = set_inc;
`ifdef MOD_N_COUNTER_LOAD_EN
  assign if0.load = load;  assign if0.load_val = load_val[2:0];
  assign if1.load = load;  assign if1.load_val = load_val[3:0];
  assign if2.load = load;  assign if2.load_val = load_val[3:0];
  assign if3.load = load;  assign if3.load_val = load_val[4:0];
`endif

  mod_n_digit_counter #(.MODULUS(SEC_HI_MOD), .WIDTH(3)) u0 (.clkmain(clkmain), .clear_n(clear_n), .bus(if0.slave));
  mod_n_digit_counter #(.MODULUS(SEC_LO_MOD), .WIDTH(4)) u1 (.clkmain(clkmain), .clear_n(clear_n), .bus(if1.slave));
  mod_n_digit_counter #(.MODULUS(16),         .WIDTH(4)) u2 (.clkmain(clkmain), .clear_n(clear_n), .bus(if2.slave));
  mod_n_digit_counter #(.MODULUS(HR_MOD),     .WIDTH(5)) u3 (.clkmain(clkmain), .clear_n(clear_n), .bus(if3.slave));

  logic [31:0] obs_count [N];
  logic [31:0] obs_carry [N];
  logic [31:0] obs_term  [N];
  assign obs_count[0] = 32'(if0.count);  assign obs_carry[0] = 32'(if0.carry);  assign obs_term[0] = 32'(if0.at_term);
  assign obs_count[1] = 32'(if1.count);  assign obs_carry[1] = 32'(if1.carry);  assign obs_term[1] = 32'(if1.at_term);
  assign obs_count[2] = 32'(if2.count);  assign obs_carry[2] = 32'(if2.carry);  assign obs_term[2] = 32'(if2.at_term);
  assign obs_count[3] = 32'(if3.count);  assign obs_carry[3] = 32'(if3.carry);  assign obs_term[3] = 32'(if3.at_term);

  // Reference model state.
  int mods   [N] = '{SEC_HI_MOD, SEC_LO_MOD, 16, HR_MOD};
  int widths [N] = '{3, 4, 4, 5};
  int mcnt   [N];
  int mcar   [N];
  bit mprev;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mcnt[i] = 0;
      mcar[i] = 0;
    end
    mprev = 1'b0;
  endtask

  // Apply one rising clock edge to the model using the current inputs.
  task automatic model_edge();
    bit step_req;
    int lv;
    step_req = set_inc && !mprev;
    for (int i = 0; i < N; i++) begin
      if (load) begin
        lv      = int'(load_val) % (1 << widths[i]);
        mcnt[i] = (lv > mods[i] - 1) ? mods[i] - 1 : lv;
        mcar[i] = 0;
      end else if (set_time) begin
        mcar[i] = 0;
        if (step_req) mcnt[i] = up_dn ? (mcnt[i] + 1) % mods[i] : (mcnt[i] + mods[i] - 1) % mods[i];
      end else if (cnt_en) begin
        mcar[i] = up_dn ? int'(mcnt[i] == mods[i] - 1) : int'(mcnt[i] == 0);
        mcnt[i] = up_dn ? (mcnt[i] + 1) % mods[i] : (mcnt[i] + mods[i] - 1) % mods[i];
      end else begin
        mcar[i] = 0;
      end
    end
    mprev = set_inc;
  endtask

  task automatic check_all(input string tag);
    int term;
    for (int i = 0; i < N; i++) begin
      term = up_dn ? int'(mcnt[i] == mods[i] - 1) : int'(mcnt[i] == 0);
      check($sformatf("%s.count[m%0d]", tag, mods[i]), obs_count[i], 32'(mcnt[i]));
      check($sformatf("%s.carry[m%0d]", tag, mods[i]), obs_carry[i], 32'(mcar[i]));
      check($sformatf("%s.at_term[m%0d]", tag, mods[i]), obs_term[i], 32'(term));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clkmain);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    int saved;
    clear_n = 1'b0; cnt_en = 1'b0; up_dn = 1'b1; set_time = 1'b0;
    set_inc = 1'b0; load = 1'b0; load_val = '0;
    model_reset();

    // Reset state, terminal flag in both directions.
    #12;
    check_all("reset");
    up_dn = 1'b0;
    #1;
    check_all("reset_dn_term");
    up_dn = 1'b1;
    @(negedge clkmain);
    clear_n = 1'b1;

    // Up counting across wraps.
    cnt_en = 1'b1;
    repeat (12) tick("up");

    // Asynchronous clear mid-count, observed before any edge.
    repeat (3) tick("up3");
    check("pre_clear.count[m6]", obs_count[0], 32'd3);
    #2;
    clear_n = 1'b0;
    model_reset();
    #1;
    check_all("async_clear");
    @(negedge clkmain);
    clear_n = 1'b1;

    // Borrow from zero.
    up_dn = 1'b0;
    tick("dn_borrow");
    check("dn_borrow.count[m10]", obs_count[1], 32'd9);
    tick("dn_next");
    check("dn_next.count[m10]", obs_count[1], 32'd8);

    // Set mode: held request steps once, then six pulses.
    up_dn = 1'b1; set_time = 1'b1; cnt_en = 1'b1;
    saved = mcnt[0];
    set_inc = 1'b1;
    repeat (5) tick("set_held");
    set_inc = 1'b0;
    tick("set_release");
    repeat (6) begin
      set_inc = 1'b1; tick("set_pulse");
      set_inc = 1'b0; tick("set_gap");
    end
    check("set_total.count[m6]", obs_count[0], 32'((saved + 7) % 6));

    // Request already high on set-mode entry gives no step.
    set_time = 1'b0; cnt_en = 1'b0; set_inc = 1'b1;
    tick("entry_pre");
    set_time = 1'b1;
    saved = mcnt[1];
    tick("entry_held");
    tick("entry_held2");
    check("entry_nostep.count[m10]", obs_count[1], 32'(saved));
    set_inc = 1'b0;
    tick("entry_low");

    // Leaving set mode on an edge cycle drops the edge.
    set_time = 1'b0; set_inc = 1'b1;
    tick("mode_switch");
    set_inc = 1'b0;

    // Hold at count 4 (mod 6).
    cnt_en = 1'b1;
    for (int k = 0; k < 8 && mcnt[0] != 4; k++) tick("seek4");
    check("seek4.count[m6]", obs_count[0], 32'd4);
    cnt_en = 1'b0;
    repeat (10) tick("hold");

    // Full-range wrap 15 -> 0 on the mod-16 digit.
    cnt_en = 1'b1;
    for (int k = 0; k < 20 && mcnt[2] != 15; k++) tick("seek15");
    tick("wrap16");
    check("wrap16.carry[m16]", obs_carry[2], 32'd1);

`ifdef MOD_N_COUNTER_LOAD_EN
    // Load clamps to the terminal value and overrides set mode.
    load = 1'b1; load_val = 5'd7;
    tick("load7");
    check("load7.count[m6]", obs_count[0], 32'd5);
    load = 1'b0; set_time = 1'b1; set_inc = 1'b0;
    tick("load_prep");
    load = 1'b1; load_val = 5'd2; set_inc = 1'b1;
    tick("load_vs_set");
    check("load_vs_set.count[m24]", obs_count[3], 32'd2);
    load = 1'b0; set_inc = 1'b0; set_time = 1'b0;
`endif

    // Randomised mixed traffic.
    repeat (300) begin
      cnt_en   = 1'($urandom_range(0, 1));
      up_dn    = 1'($urandom_range(0, 1));
      set_time = ($urandom_range(0, 3) == 0);
      set_inc  = 1'($urandom_range(0, 1));
`ifdef MOD_N_COUNTER_LOAD_EN
      load     = ($urandom_range(0, 15) == 0);
      load_val = 5'($urandom);
`endif
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
